// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Byte address to word index: drop the two byte-offset bits.
  localparam int WORD_SHIFT = 2;

  // Widths of the latched request fields (match the default port widths).
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_e;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_e;

  // One in-flight memory access.
  typedef struct packed {
    port_e                 owner;
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant select between the fetch (I) and load/store (D) ports.
// Default build: fixed D-over-I priority, purely combinational.
// With MEM_ARB_RR_EN defined: round-robin on simultaneous requests, using a
// one-bit pointer that names the port to favour next.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic  clk,
  input  logic  rst,
  input  logic  accept_i,
`endif
  input  logic  i_valid_i,
  input  logic  d_valid_i,
  output port_e grant_o
);

`ifdef MEM_ARB_RR_EN
  port_e ptr_q;

  // Favour the pointed-to port on a tie; otherwise grant whoever is asking.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_o = PORT_I;
    if (i_valid_i && d_valid_i) grant_o = ptr_q;
    else if (d_valid_i)         grant_o = PORT_D;
  end

  // Point at the port that was not just served; move only on acceptance.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch.
    if (rst)           ptr_q <= PORT_D;
    else if (accept_i) ptr_q <= (grant_o == PORT_D) ? PORT_I : PORT_D;
  end
`else
  // Fixed priority: D wins whenever it is valid.
  always_comb begin
    grant_o = d_valid_i ? PORT_D : PORT_I;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and
// load/store. One request at a time: accept (IDLE) -> strobe (ISSUE) ->
// respond (RESP). Optional round-robin arbitration via MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_rdata,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q;
  req_t       req_q, req_d;
  port_e      grant;
  logic       accept;
  logic       i_resp_valid_q, d_resp_valid_q;

  // Reset blocks acceptance; only the granted, valid port is told ready.
  assign accept      = !rst && (state_q == IDLE) &&
                       ((grant == PORT_D) ? d_req_valid : i_req_valid);
  assign i_req_ready = accept && (grant == PORT_I);
  assign d_req_ready = accept && (grant == PORT_D);

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
    .accept_i (accept),
`endif
    .i_valid_i(i_req_valid),
    .d_valid_i(d_req_valid),
    .grant_o  (grant)
  );

  // Build the request record for whichever port holds the grant.
  always_comb begin
    req_d       = '0;
    req_d.owner = grant;
    if (grant == PORT_D) begin
      req_d.we    = d_req_we;
      req_d.addr  = REQ_ADDR_W'(d_req_addr);
      req_d.wdata = REQ_DATA_W'(d_req_wdata);
    end else begin
      req_d.addr  = REQ_ADDR_W'(i_req_addr);
    end
  end

  // Sequencer: state, latched request and registered response strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_q          <= '0;
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          req_q   <= req_d;
          state_q <= ISSUE;
        end
        ISSUE: begin
          i_resp_valid_q <= (req_q.owner == PORT_I);
          d_resp_valid_q <= (req_q.owner == PORT_D);
          state_q        <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes and bus are driven only during ISSUE, zero otherwise.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ISSUE) begin
      mem_read  = !req_q.we;
      mem_write = req_q.we;
      mem_addr  = 32'(req_q.addr >> WORD_SHIFT);
      mem_wdata = DATA_W'(req_q.wdata);
    end
  end

  // Responses: a reset in RESP suppresses the response; read data is
  // forwarded only on a load response, never on an idle cycle or store ack.
  always_comb begin
    i_resp_valid = i_resp_valid_q && !rst;
    d_resp_valid = d_resp_valid_q && !rst;
    i_resp_rdata = '0;
    d_resp_rdata = '0;
    if (i_resp_valid && !req_q.we) i_resp_rdata = mem_rdata;
    if (d_resp_valid && !req_q.we) d_resp_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of per-cycle vectors plus
// hand-written reset-in-flight and contention sequences. Inputs are driven
// 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0] i_req_addr, i_resp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_resp_valid(i_resp_valid),
    .i_resp_rdata(i_resp_rdata),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_we    (d_req_we),
    .d_req_addr  (d_req_addr),
    .d_req_wdata (d_req_wdata),
    .d_resp_valid(d_resp_valid),
    .d_resp_rdata(d_resp_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata)
  );

  // 32x32 memory model, registered read, read over write; word 3 preloaded.
  logic [31:0] mem_arr [32];
  logic        pre_we;
  always @(posedge clk) begin
    if (pre_we)         mem_arr[3] <= 32'h00A0_0093;
    else if (mem_read)  mem_rdata <= mem_arr[mem_addr[4:0]];
    else if (mem_write) mem_arr[mem_addr[4:0]] <= mem_wdata;
  end

  typedef struct {
    logic        rst, iv, dv, dwe;
    logic [31:0] ia, da, dwd;
    logic        ir, dr, mr, mw, irv, drv;
    logic [31:0] ma, mwd, ird, drd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic iv, input logic [31:0] ia,
    input logic dv, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
    input logic ir, input logic dr, input logic mr, input logic mw,
    input logic [31:0] ma, input logic [31:0] mwd,
    input logic irv, input logic [31:0] ird, input logic drv, input logic [31:0] drd);
    vec_t v;
    v.rst = 1'b0; v.iv = iv; v.ia = ia; v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.ir = ir; v.dr = dr; v.mr = mr; v.mw = mw; v.ma = ma; v.mwd = mwd;
    v.irv = irv; v.ird = ird; v.drv = drv; v.drd = drd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] ia,
                       input logic dv, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd);
    rst = r; i_req_valid = iv; i_req_addr = ia;
    d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd;
  endtask

  task automatic expect_all(input string tag,
    input logic ir, input logic dr, input logic mr, input logic mw,
    input logic [31:0] ma, input logic [31:0] mwd,
    input logic irv, input logic [31:0] ird, input logic drv, input logic [31:0] drd);
    check({tag, ".i_req_ready"},  {31'b0, i_req_ready},  {31'b0, ir});
    check({tag, ".d_req_ready"},  {31'b0, d_req_ready},  {31'b0, dr});
    check({tag, ".mem_read"},     {31'b0, mem_read},     {31'b0, mr});
    check({tag, ".mem_write"},    {31'b0, mem_write},    {31'b0, mw});
    check({tag, ".mem_addr"},     mem_addr,              ma);
    check({tag, ".mem_wdata"},    mem_wdata,             mwd);
    check({tag, ".i_resp_valid"}, {31'b0, i_resp_valid}, {31'b0, irv});
    check({tag, ".i_resp_rdata"}, i_resp_rdata,          ird);
    check({tag, ".d_resp_valid"}, {31'b0, d_resp_valid}, {31'b0, drv});
    check({tag, ".d_resp_rdata"}, d_resp_rdata,          drd);
  endtask

  initial begin
    bit          acc_at [12];
    bit          acc_d  [12];
    int          n_acc;
    int          acc_cyc [4];
    bit          acc_port [4];
    bit          exp_port;
    logic        exp_iv, exp_dv;

    // Store 0x14 then load it back, fetch word 3, then a misaligned D load
    // with an I request pulsed only during its RESP cycle.
    //   iv ia        dv we da        dwd           ir dr mr mw ma mwd           irv ird           drv drd
    add(0, 0,         0, 0, 0,        0,            0, 0, 0, 0, 0, 0,            0, 0,             0, 0);
    add(0, 0,         1, 1, 32'h14,   32'hDEADBEEF, 0, 1, 0, 0, 0, 0,            0, 0,             0, 0);
    add(0, 0,         0, 0, 0,        0,            0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0,             0, 0);
    add(0, 0,         0, 0, 0,        0,            0, 0, 0, 0, 0, 0,            0, 0,             1, 0);
    add(0, 0,         1, 0, 32'h14,   0,            0, 1, 0, 0, 0, 0,            0, 0,             0, 0);
    add(0, 0,         0, 0, 0,        0,            0, 0, 1, 0, 5, 0,            0, 0,             0, 0);
    add(0, 0,         0, 0, 0,        0,            0, 0, 0, 0, 0, 0,            0, 0,             1, 32'hDEADBEEF);
    add(1, 32'h0C,    0, 0, 0,        0,            1, 0, 0, 0, 0, 0,            0, 0,             0, 0);
    add(0, 0,         0, 0, 0,        0,            0, 0, 1, 0, 3, 0,            0, 0,             0, 0);
    add(0, 0,         0, 0, 0,        0,            0, 0, 0, 0, 0, 0,            1, 32'h00A00093,  0, 0);
    add(0, 0,         1, 0, 32'h17,   32'h12345678, 0, 1, 0, 0, 0, 0,            0, 0,             0, 0);
    add(0, 0,         0, 0, 0,        0,            0, 0, 1, 0, 5, 32'h12345678, 0, 0,             0, 0);
    add(1, 32'h08,    0, 0, 0,        0,            0, 0, 0, 0, 0, 0,            0, 0,             1, 32'hDEADBEEF);
    add(0, 0,         0, 0, 0,        0,            0, 0, 0, 0, 0, 0,            0, 0,             0, 0);
    add(0, 0,         0, 0, 0,        0,            0, 0, 0, 0, 0, 0,            0, 0,             0, 0);

    // Reset, with a D request held: ready must stay low, outputs all zero.
    pre_we = 1'b1;
    drive(1, 0, 0, 1, 0, 32'h14, 0);
    @(posedge clk); #1;
    @(negedge clk);
    expect_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    pre_we = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Table-driven vectors, one row per cycle.
    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk); #1;
      drive(vecs[k].rst, vecs[k].iv, vecs[k].ia, vecs[k].dv, vecs[k].dwe, vecs[k].da, vecs[k].dwd);
      @(negedge clk);
      expect_all($sformatf("vec%0d", k), vecs[k].ir, vecs[k].dr, vecs[k].mr, vecs[k].mw,
                 vecs[k].ma, vecs[k].mwd, vecs[k].irv, vecs[k].ird, vecs[k].drv, vecs[k].drd);
    end

    // Reset mid-access: I load of 0x0C accepted, rst pulsed in ISSUE.
    @(posedge clk); #1;
    drive(0, 1, 32'h0C, 0, 0, 0, 0);
    @(negedge clk);
    check("rstmid.accept", {31'b0, i_req_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rstmid.issue_strobe", {31'b0, mem_read}, 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_all("rstmid.after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    expect_all("rstmid.noresp", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Contention: both ports valid for 12 cycles, responses must reach only
    // the owner of the acceptance two cycles earlier.
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      drive(0, 1, 32'h0C, 1, 0, 32'h14, 0);
      @(negedge clk);
      acc_at[c] = i_req_ready || d_req_ready;
      acc_d[c]  = d_req_ready;
      check($sformatf("ctn%0d.both_ready", c), {31'b0, i_req_ready && d_req_ready}, 32'd0);
      if (acc_at[c] && n_acc < 4) begin
        acc_cyc[n_acc]  = c;
        acc_port[n_acc] = d_req_ready;
      end
      if (acc_at[c]) n_acc++;
      exp_iv = (c >= 2) && acc_at[c-2] && !acc_d[c-2];
      exp_dv = (c >= 2) && acc_at[c-2] &&  acc_d[c-2];
      check($sformatf("ctn%0d.i_resp_valid", c), {31'b0, i_resp_valid}, {31'b0, exp_iv});
      check($sformatf("ctn%0d.d_resp_valid", c), {31'b0, d_resp_valid}, {31'b0, exp_dv});
      check($sformatf("ctn%0d.i_resp_rdata", c), i_resp_rdata, exp_iv ? 32'h00A00093 : 32'h0);
      check($sformatf("ctn%0d.d_resp_rdata", c), d_resp_rdata, exp_dv ? 32'hDEADBEEF : 32'h0);
    end
    check("ctn.n_accept", n_acc, 4);
    for (int j = 0; j < 4 && j < n_acc; j++) begin
`ifdef MEM_ARB_RR_EN
      exp_port = (j % 2 == 0);
`else
      exp_port = 1'b1;
`endif
      check($sformatf("ctn.acc%0d_cycle", j), acc_cyc[j], 3 * j);
      check($sformatf("ctn.acc%0d_is_d", j), {31'b0, acc_port[j]}, {31'b0, exp_port});
    end

    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete within 20000 ns");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer in front of the core's single-port word memory (32×32, one-cycle registered read, read has priority over write). It shares that memory between instruction fetch (I-port) and load/store (D-port). It latches one request at a time, drives `mem_read`/`mem_write` for exactly one cycle, and returns read data or a write acknowledgement to the winning requester. It sits between the fetch/LSU stages and the memory instance.

## Interface
- `ADDR_W`, 32, requester byte-address width
- `DATA_W`, 32, data width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_req_valid`  in  1  fetch request
- `i_req_ready`  out  1  fetch request accepted this cycle
- `i_req_addr`  in  ADDR_W  fetch byte address
- `i_resp_valid`  out  1  fetch data valid (one cycle)
- `i_resp_rdata`  out  DATA_W  fetch data
- `d_req_valid`  in  1  load/store request
- `d_req_ready`  out  1  load/store request accepted this cycle
- `d_req_we`  in  1  1 = store, 0 = load
- `d_req_addr`  in  ADDR_W  load/store byte address
- `d_req_wdata`  in  DATA_W  store data
- `d_resp_valid`  out  1  load data / store ack (one cycle)
- `d_resp_rdata`  out  DATA_W  load data; 0 on store ack
- `mem_addr`  out  32  word index to memory
- `mem_wdata`  out  DATA_W  memory write data
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `mem_rdata`  in  DATA_W  memory registered read data

## Operation
- FSM states: IDLE → ISSUE → RESP → IDLE. Every transition is unconditional except IDLE→ISSUE, which requires an accepted request.
- IDLE:
  - `x_req_ready` is combinational: 1 only for the granted port, and only when that port's valid is 1.
  - On acceptance, latch owner, `we`, `addr`, `wdata` into a request register.
- Grant:
  - Both valid: D-port wins (fixed priority).
  - One valid: that port wins.
  - Withdrawing valid before acceptance is legal; no side effects.
- ISSUE:
  - `mem_addr = {2'b0, addr[31:2]}`; low two address bits are ignored (no misalignment fault).
  - `mem_read` = 1 if `!we`; `mem_write` = 1 if `we`. Never both.
  - `mem_wdata` = latched wdata.
- RESP:
  - Owner's `resp_valid` = 1.
  - Read: `resp_rdata` = `mem_rdata`. Write: `resp_rdata` = 0.
  - Non-owner `resp_valid` = 0.
- Responses cannot be back-pressured; requesters must sink them.
- Outside ISSUE: `mem_read` = `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0. Idle-cycle `mem_rdata` (X) is never forwarded.
- Both `resp_rdata` outputs are 0 when their `resp_valid` is 0.

## Timing
- Request accepted in cycle N → memory strobe in N+1 → response in N+2.
- Next acceptance no earlier than N+3. Peak throughput is one access per 3 cycles.
- Reset values:
  - state IDLE; request register 0.
  - all `*_ready`, `*_resp_valid`, `mem_read`, `mem_write` = 0.
  - all data and address outputs = 0.
  - round-robin pointer (when compiled in) points at D-port.
- `rst` in ISSUE or RESP: next cycle in IDLE. The in-flight transaction is dropped: no response is produced, and a store whose strobe was already sampled remains written.
- `rst` high overrides acceptance: `*_req_ready` = 0 while `rst` = 1.
- Requests presented during ISSUE/RESP see `ready` = 0 and must hold until accepted.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration. On simultaneous requests, the port not granted most recently wins.
  - The pointer updates only on acceptance.
- `MEM_ARB_RR_EN` undefined: fixed D-over-I priority. No pointer flop is built.

## Structure
- `mem_arb_pkg` holds:
  - `arb_state_e` {IDLE, ISSUE, RESP}
  - `port_e` {PORT_I, PORT_D}
  - a request struct (owner, we, addr, wdata)
  - `WORD_SHIFT` = 2
- One sub-module, `mem_arb_grant`: combinational grant select, with a pointer flop under `MEM_ARB_RR_EN`. All sequencing stays in `mem_port_arbiter`.

## Test plan
- **Reset mid-access:** I-load `addr` 0x0C accepted, `rst` pulsed in ISSUE → no `i_resp_valid`; all outputs 0 the cycle after `rst`.
- **Single store then load:** D store `addr` 0x14 data 0xDEADBEEF.
  - Cycle N+1: `mem_write` = 1, `mem_addr` = 5.
  - Cycle N+2: `d_resp_valid` = 1, `rdata` = 0.
  - Follow-up D load of 0x14: `d_resp_rdata` = 0xDEADBEEF in its N+2.
- **Fetch read:** after preloading word 3 with 0x00A00093, I-req 0x0C → `i_resp_valid` 2 cycles after accept with 0x00A00093; `d_resp_valid` stays 0.
- **Contention, fixed priority:** both ports valid continuously → D granted every acceptance, I starved; acceptances 3 cycles apart.
- **Contention, `MEM_ARB_RR_EN`:** both ports valid continuously → grants alternate D, I, D, I; each response routed only to its owner.
- **Withdrawal and misalignment:**
  - I-valid pulsed for one cycle during RESP → no access issued.
  - D load at 0x17 → `mem_addr` = 5.
